// File: rtl/wb_bram_burst.sv
// wb_bram_burst
//   Wishbone B4 slave block RAM with byte-lane writes and registered-feedback
//   incremental read bursts (CTI/BTE). Frame/line buffer storage for the video
//   controller bus.
//
//   Writes are acknowledged combinationally in the request cycle. Classic reads
//   take two cycles (registered RAM output). Incremental bursts prefetch the next
//   word so that after the first beat one read is acknowledged per cycle.
//   Out-of-range addresses terminate with ERR using the timing ACK would have had.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   wb_cyc, wb_stb, wb_we bus cycle, strobe, write enable
//   wb_adr                byte address
//   wb_sel                byte-lane enables
//   wb_dat_ms             write data (master->slave)
//   wb_cti, wb_bte        cycle type / burst type
//   wb_dat_sm             read data (slave->master)
//   wb_ack, wb_err, wb_rty normal / error / retry termination (retry tied 0)
//   dbg_burst             1 while the burst FSM is in its BURST state
//
// Handshake: a request is wb_cyc & wb_stb. The master holds address, data and
// controls stable until the cycle in which wb_ack or wb_err is high; that cycle
// completes the transfer. wb_ack and wb_err are only ever high during a request.
module wb_bram_burst #(
    parameter int MEM_ADR_WIDTH = 11,
    parameter int DATA_WIDTH    = 32,
    parameter     INIT_FILE     = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [31:0]             wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_ms,
    input  logic [2:0]              wb_cti,
    input  logic [1:0]              wb_bte,
    output logic [DATA_WIDTH-1:0]   wb_dat_sm,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_rty,
    output logic                    dbg_burst
);

    localparam int ALSB  = $clog2(DATA_WIDTH / 8);
    localparam int AW    = MEM_ADR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int NSEL  = DATA_WIDTH / 8;

    localparam logic [2:0] CTI_INCR = 3'b010;

    // There is no preload path: RAM contents are undefined after power-up.
    localparam bit init_image_unused = (INIT_FILE != "");

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    ack_r;
    logic                    err_r;
    logic [AW-1:0]           tag;   // word currently held in dat_r during a burst
    logic [AW-1:0]           ptr;   // word to prefetch on the next acked beat

    logic                    req;
    logic                    in_range;
    logic [AW-1:0]           word;
    logic                    ack_w;
    logic                    err_w;
    logic                    ack_b;
    logic [31:0]             adr_low_unused;

    // Byte-offset bits below the word address carry no meaning here.
    assign adr_low_unused = wb_adr & 32'((1 << ALSB) - 1);

    // Gating with rst_n makes every termination drop the moment reset asserts.
    assign req      = wb_cyc & wb_stb & rst_n;
    assign word     = wb_adr[ALSB +: AW];
    assign in_range = (wb_adr >> (ALSB + AW)) == '0;

    assign ack_w = req & wb_we & in_range;
    assign err_w = req & wb_we & ~in_range;
    // Burst beats are acked only when the master presents exactly the word that
    // was prefetched, so a prefetched word is never acked for another address.
    assign ack_b = (state == ST_BURST) & req & ~wb_we & in_range & (word == tag);

    assign wb_ack    = ack_w | ack_b | (ack_r & req);
    assign wb_err    = ~wb_ack & (err_w | (err_r & req));
    assign wb_rty    = 1'b0;
    assign wb_dat_sm = dat_r;
    assign dbg_burst = (state == ST_BURST);

    // Burst address sequence: linear wraps modulo the depth, wrapN only steps
    // the low log2(N) bits and keeps the upper bits.
    function automatic logic [AW-1:0] next_word(input logic [AW-1:0] w,
                                                input logic [1:0]    bte);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc = w + AW'(1);
        case (bte)
            2'b01:   mask = AW'(3);
            2'b10:   mask = AW'(7);
            2'b11:   mask = AW'(15);
            default: mask = '1;
        endcase
        return (w & ~mask) | (inc & mask);
    endfunction

    always_ff @(posedge clk) begin
        if (ack_w) begin
            for (int i = 0; i < NSEL; i++) begin
                if (wb_sel[i]) begin
                    mem[word][8*i +: 8] <= wb_dat_ms[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= '0;
            tag   <= '0;
            ptr   <= '0;
        end else begin
            ack_r <= 1'b0;
            // A read error is reported one cycle late and never twice for a
            // held strobe, from either state.
            err_r <= req & ~wb_we & ~in_range & ~wb_err;
            case (state)
                ST_IDLE: begin
                    if (req && !wb_we && in_range && !wb_ack) begin
                        dat_r <= mem[word];
                        if (wb_cti == CTI_INCR) begin
                            state <= ST_BURST;
                            tag   <= word;
                            ptr   <= next_word(word, wb_bte);
                        end else begin
                            ack_r <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    // Only keep prefetching while the master says more beats
                    // follow; anything else falls back to IDLE, where the
                    // request is handled afresh.
                    if (ack_b && wb_cti == CTI_INCR) begin
                        dat_r <= mem[ptr];
                        tag   <= ptr;
                        ptr   <= next_word(ptr, wb_bte);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
